// File: rtl/rv_multicycle_ctrl.sv
// Multicycle RV32 main control FSM: sequences ALU, memory port and extender; traps on bad opcodes or bus timeout.
// Define UTYPE_EN to add lui/auipc support; undefined, both opcodes trap.
module rv_multicycle_ctrl #(
  parameter int WAIT_LIMIT = 15
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [6:0] i_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_zero,
  input  logic       i_mem_ready,
  output logic       o_mem_req,
  output logic       o_mem_write,
  output logic       o_adr_src,
  output logic       o_ir_write,
  output logic       o_pc_write,
  output logic       o_reg_write,
  output logic [1:0] o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_result_src,
  output logic [2:0] o_alu_control,
  output logic [1:0] o_imm_src,
  output logic       o_trap,
  output logic [3:0] o_state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_LUI      = 4'd10,
    S_AUIPC    = 4'd11,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

`ifdef UTYPE_EN
  localparam bit         U_EN  = 1'b1;
  localparam logic [1:0] IMM_U = 2'b11;
`else
  localparam bit         U_EN  = 1'b0;
  localparam logic [1:0] IMM_U = 2'b00;
`endif

  // A zero limit still needs a 1-bit counter; it simply never triggers.
  localparam int          CW  = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIM = CW'(WAIT_LIMIT);

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_wait_cnt;
  logic            w_mem_state;
  logic            w_timeout;
  logic            w_funct_ok;
  logic [2:0]      w_alu_dec;

  always_comb begin
    w_funct_ok = 1'b1;
    w_alu_dec  = 3'b000;
    case (i_funct3)
      3'b000:  w_alu_dec = (i_op[5] & i_funct7b5) ? 3'b001 : 3'b000;
      3'b010:  w_alu_dec = 3'b101;
      3'b110:  w_alu_dec = 3'b011;
      3'b111:  w_alu_dec = 3'b010;
      default: w_funct_ok = 1'b0;
    endcase
  end

  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMREAD) || (r_state == S_MEMWRITE);
  assign w_timeout   = (WAIT_LIMIT != 0) && (r_wait_cnt == LIM) && !i_mem_ready;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:    if (i_mem_ready) w_next = S_DECODE; else if (w_timeout) w_next = S_TRAP;
      S_DECODE: begin
        case (i_op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = w_funct_ok ? S_EXECR : S_TRAP;
          OP_I:         w_next = w_funct_ok ? S_EXECI : S_TRAP;
          OP_BEQ:       w_next = S_BEQ;
          OP_LUI:       w_next = U_EN ? S_LUI : S_TRAP;
          OP_AUIPC:     w_next = U_EN ? S_AUIPC : S_TRAP;
          default:      w_next = S_TRAP;
        endcase
      end
      S_MEMADR:   w_next = (i_op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (i_mem_ready) w_next = S_MEMWB; else if (w_timeout) w_next = S_TRAP;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: if (i_mem_ready) w_next = S_FETCH; else if (w_timeout) w_next = S_TRAP;
      S_EXECR:    w_next = S_ALUWB;
      S_EXECI:    w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_BEQ:      w_next = S_FETCH;
      S_LUI:      w_next = S_FETCH;
      S_AUIPC:    w_next = S_ALUWB;
      S_TRAP:     w_next = S_TRAP;
      default:    w_next = S_TRAP;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_FETCH;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_wait_cnt <= '0;
      else if (w_mem_state && !i_mem_ready)
        r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  always_comb begin
    o_mem_req     = 1'b0;
    o_mem_write   = 1'b0;
    o_adr_src     = 1'b0;
    o_ir_write    = 1'b0;
    o_pc_write    = 1'b0;
    o_reg_write   = 1'b0;
    o_alu_src_a   = 2'b00;
    o_alu_src_b   = 2'b00;
    o_result_src  = 2'b00;
    o_alu_control = 3'b000;
    o_trap        = 1'b0;
    case (r_state)
      S_FETCH: begin
        o_mem_req    = 1'b1;
        o_alu_src_b  = 2'b10;
        o_result_src = 2'b10;
        o_ir_write   = i_mem_ready;
        o_pc_write   = i_mem_ready;
      end
      S_DECODE:   begin o_alu_src_a = 2'b01; o_alu_src_b = 2'b01; end
      S_MEMADR:   begin o_alu_src_a = 2'b10; o_alu_src_b = 2'b01; end
      S_MEMREAD:  begin o_mem_req = 1'b1; o_adr_src = 1'b1; end
      S_MEMWB:    begin o_result_src = 2'b01; o_reg_write = 1'b1; end
      S_MEMWRITE: begin o_mem_req = 1'b1; o_mem_write = 1'b1; o_adr_src = 1'b1; end
      S_EXECR:    begin o_alu_src_a = 2'b10; o_alu_control = w_alu_dec; end
      S_EXECI:    begin o_alu_src_a = 2'b10; o_alu_src_b = 2'b01; o_alu_control = w_alu_dec; end
      S_ALUWB:    o_reg_write = 1'b1;
      S_BEQ: begin
        o_alu_src_a   = 2'b10;
        o_alu_control = 3'b001;
        o_pc_write    = i_zero;
      end
      S_LUI:      begin o_reg_write = 1'b1; o_result_src = 2'b11; end
      S_AUIPC:    begin o_alu_src_a = 2'b01; o_alu_src_b = 2'b01; end
      S_TRAP:     o_trap = 1'b1;
      default:    o_trap = 1'b1;
    endcase
    // Reset must never let a write through, even the Mealy ones in FETCH.
    if (i_rst) begin
      o_ir_write  = 1'b0;
      o_pc_write  = 1'b0;
      o_reg_write = 1'b0;
      o_mem_write = 1'b0;
    end
  end

  always_comb begin
    o_imm_src = 2'b00;
    case (i_op)
      OP_SW:            o_imm_src = 2'b01;
      OP_BEQ:           o_imm_src = 2'b10;
      OP_LUI, OP_AUIPC: o_imm_src = IMM_U;
      default:          o_imm_src = 2'b00;
    endcase
  end

  assign o_state = r_state;

endmodule
